// File: rtl/smac_pkg.sv
// rtl/smac_pkg.sv - shared types and width helpers for the FULL_SMAC datapath
//
// Purpose: state encoding of the bit-plane accumulator and the width
//          functions used to size its popcount input and result.
// Ports:   none (package).
package smac_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } bpa_state_t;

    // Popcount width for M lanes: must hold the value M itself.
    function automatic int bpa_pop_w(input int m);
        return $clog2(m) + 1;
    endfunction

    // Result width: unsigned max M*(2^N-1) plus one sign bit.
    function automatic int bpa_acc_w(input int m, input int n);
        return $clog2(m) + n + 1;
    endfunction

endpackage

// File: rtl/bitplane_accumulator.sv
// rtl/bitplane_accumulator.sv - MSB-first shift-and-add reduction of bit-plane popcounts
//
// Purpose: consumes N per-plane popcounts (MSB plane first) and reduces them
//          with the Horner recurrence acc = 2*acc + pop into one weighted
//          dot-product result, presented on a valid/ready output.
// Build option: BITPLANE_SIGNED_EN - when defined the first (MSB) plane is
//          weighted negatively, giving a two's-complement result.
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   start      one-cycle pulse, begins an operation (honoured only in IDLE)
//   in_valid   in_pop carries a plane popcount
//   in_ready   accumulator accepts a plane this cycle
//   in_pop     plane popcount, P bits, MSB plane first
//   out_valid  out_sum holds a finished result
//   out_ready  downstream accepts out_sum
//   out_sum    accumulated result, ACC_W bits, two's complement
//   busy       operation in progress (ACC or DONE)

// Down-counter over the planes of one operation; zero marks the last plane.
module plane_counter
    import smac_pkg::*;
#(
    parameter int N  = 8,
    parameter int CW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          dec,
    output logic          zero,
    output logic [CW-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= CW'(N - 1);
        end else if (dec) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

module bitplane_accumulator
    import smac_pkg::*;
#(
    parameter int M     = 16,
    parameter int N     = 8,
    parameter int P     = bpa_pop_w(M),
    parameter int ACC_W = bpa_acc_w(M, N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [P-1:0]     in_pop,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             busy
);

    localparam int CW = $clog2(N);

    bpa_state_t       state;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_next;
    logic [ACC_W-1:0] pop_ext;
    logic             first;
    logic             transfer;
    logic             cnt_load;
    logic             cnt_zero;
    logic [CW-1:0]    cnt_value;

    // in_ready is only ever high in ACC, so this is the plane handshake.
    assign transfer = in_valid && in_ready;
    assign cnt_load = (state == IDLE) && start;

    plane_counter #(
        .N  (N),
        .CW (CW)
    ) u_plane_counter (
        .clk   (clk),
        .rst   (rst),
        .load  (cnt_load),
        .dec   (transfer),
        .zero  (cnt_zero),
        .count (cnt_value)
    );

    assign pop_ext = ACC_W'(in_pop);

    always_comb begin
        acc_next = (acc << 1) + pop_ext;
`ifdef BITPLANE_SIGNED_EN
        // MSB plane carries weight -2^(N-1); acc is zero here so only the
        // negated popcount remains.
        if (first) begin
            acc_next = '0 - pop_ext;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            first     <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= ACC;
                        acc      <= '0;
                        first    <= 1'b1;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                ACC: begin
                    if (transfer) begin
                        acc   <= acc_next;
                        first <= 1'b0;
                        if (cnt_zero) begin
                            state     <= DONE;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            out_sum   <= acc_next;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bitplane_accumulator.sv
// tb/tb_bitplane_accumulator.sv - directed self-checking bench for bitplane_accumulator
module tb_bitplane_accumulator;

    localparam int M     = 16;
    localparam int N     = 4;
    localparam int P     = 5;
    localparam int ACC_W = 9;

`ifdef BITPLANE_SIGNED_EN
    localparam logic [8:0] EXP_BASIC = 9'd9;
    localparam logic [8:0] EXP_MSB   = 9'h180;
    localparam logic [8:0] EXP_MAX   = 9'h1F0;
    localparam logic [8:0] EXP_ONES  = 9'h1FF;
`else
    localparam logic [8:0] EXP_BASIC = 9'd57;
    localparam logic [8:0] EXP_MSB   = 9'd128;
    localparam logic [8:0] EXP_MAX   = 9'd240;
    localparam logic [8:0] EXP_ONES  = 9'd15;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             in_valid;
    logic             in_ready;
    logic [P-1:0]     in_pop;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic             busy;

    int total = 0;
    int bad   = 0;
    int lat;

    always #5 clk = ~clk;

    bitplane_accumulator #(
        .M (M),
        .N (N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pop    (in_pop),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts an op and feeds four planes; optional stall before plane 3 and
    // optional start pulse alongside plane 2. lat counts cycles from the start
    // cycle until out_valid is seen (bounded).
    task automatic run_op(input logic [4:0] p0, input logic [4:0] p1,
                          input logic [4:0] p2, input logic [4:0] p3,
                          input int stall, input bit start_mid, output int l);
        logic [4:0] pops [4];
        pops[0] = p0; pops[1] = p1; pops[2] = p2; pops[3] = p3;
        start = 1'b1;
        tick();
        start = 1'b0;
        l = 1;
        for (int i = 0; i < 4; i++) begin
            if (i == 2 && stall > 0) begin
                in_valid = 1'b0;
                for (int s = 0; s < stall; s++) begin
                    tick();
                    l++;
                end
                chk("stall_ready", {31'd0, in_ready}, 32'd1);
                chk("stall_valid", {31'd0, out_valid}, 32'd0);
            end
            in_valid = 1'b1;
            in_pop   = pops[i];
            start    = start_mid && (i == 1);
            tick();
            l++;
            start = 1'b0;
        end
        in_valid = 1'b0;
        in_pop   = '0;
        while (!out_valid && l < 40) begin
            tick();
            l++;
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("drain_valid", {31'd0, out_valid}, 32'd0);
        chk("drain_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_pop = '0; out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_sum", {23'd0, out_sum}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);

        // in_valid while IDLE without start: nothing happens
        in_valid = 1'b1; in_pop = 5'd7;
        tick();
        tick();
        chk("idle_ready", {31'd0, in_ready}, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        in_valid = 1'b0;

        // basic op, with a start pulse during ACC that must be ignored
        run_op(5'd3, 5'd0, 5'd16, 5'd1, 0, 1'b1, lat);
        chk("basic_lat", lat, 32'd5);
        chk("basic_valid", {31'd0, out_valid}, 32'd1);
        chk("basic_sum", {23'd0, out_sum}, {23'd0, EXP_BASIC});
        drain();

        // MSB plane only
        run_op(5'd16, 5'd0, 5'd0, 5'd0, 0, 1'b0, lat);
        chk("msb_sum", {23'd0, out_sum}, {23'd0, EXP_MSB});
        drain();

        // max popcounts with a 2-cycle stall between planes 2 and 3
        run_op(5'd16, 5'd16, 5'd16, 5'd16, 2, 1'b0, lat);
        chk("max_lat", lat, 32'd7);
        chk("max_sum", {23'd0, out_sum}, {23'd0, EXP_MAX});
        drain();

        // backpressure: result held, in_ready low, stray start ignored
        run_op(5'd3, 5'd0, 5'd16, 5'd1, 0, 1'b0, lat);
        for (int c = 0; c < 5; c++) begin
            start = (c == 2);
            tick();
            start = 1'b0;
            chk("bp_sum", {23'd0, out_sum}, {23'd0, EXP_BASIC});
            chk("bp_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
        end
        // start coinciding with the output handshake is not taken
        start = 1'b1;
        out_ready = 1'b1;
        tick();
        start = 1'b0;
        out_ready = 1'b0;
        chk("b2b_valid", {31'd0, out_valid}, 32'd0);
        chk("b2b_busy", {31'd0, busy}, 32'd0);
        tick();
        chk("b2b_idle", {31'd0, busy}, 32'd0);

        // reset after two planes aborts the op
        start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_pop = 5'd9;
        tick();
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_sum", {23'd0, out_sum}, 32'd0);
        chk("abort_ready", {31'd0, in_ready}, 32'd0);

        run_op(5'd1, 5'd1, 5'd1, 5'd1, 0, 1'b0, lat);
        chk("ones_lat", lat, 32'd5);
        chk("ones_sum", {23'd0, out_sum}, {23'd0, EXP_ONES});
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
